rat_alu_flags: RTL and testbench

Execute stage of the RAT CPU, directly downstream of the 32×8 register file. It takes the two register read ports, with an optional 8-bit immediate on the Y side, and computes an 8-bit ALU result that returns to the register-file write-data mux. It also owns the architectural C and Z flag registers and their interrupt shadow copies. The control unit drives every flag load, set, clear, save and restore strobe.

---
 rtl/rat_alu_pkg.sv | 32 +++
 rtl/rat_alu_core.sv | 112 +++++++++++
 rtl/rat_alu_flags.sv | 102 ++++++++++
 tb/tb_rat_alu_flags.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_alu_pkg.sv
// ---------------------------------------------------------------------------
// rat_alu_pkg
// Shared definitions for the RAT CPU execute stage.
//   DATA_W   : datapath width, fixed to match the 32x8 register file
//   alu_op_t : 4-bit operation code driven by the control unit on ALU_SEL
// ---------------------------------------------------------------------------
package rat_alu_pkg;

  localparam int DATA_W = 8;

  // Encodings are fixed by the instruction decoder, so every value is pinned
  // explicitly rather than relying on enum auto-numbering.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBC = 4'd3,
    ALU_CMP  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_EXOR = 4'd7,
    ALU_TEST = 4'd8,
    ALU_LSL  = 4'd9,
    ALU_LSR  = 4'd10,
    ALU_ROL  = 4'd11,
    ALU_ROR  = 4'd12,
    ALU_ASR  = 4'd13,
    ALU_MOV  = 4'd14,
    ALU_RSVD = 4'd15
  } alu_op_t;

endpackage

// File: rtl/rat_alu_core.sv
// ---------------------------------------------------------------------------
// rat_alu_core
// Purely combinational 8-bit ALU for the RAT CPU.
//   i_a      : X operand
//   i_b      : Y operand (already muxed between register and immediate)
//   i_cin    : carry-in, the registered C flag from before the clock edge
//   i_op     : operation code
//   o_result : 8-bit result
//   o_carry  : carry / borrow / shifted-out bit, depending on the operation
//   o_zero   : high when o_result is all zeros, for every operation
// ---------------------------------------------------------------------------
module rat_alu_core
  import rat_alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  input  alu_op_t           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  // Arithmetic is done one bit wider than the datapath so that bit 8 of the
  // sum is the carry and bit 8 of the difference is the borrow.
  logic [DATA_W:0] w_a9;
  logic [DATA_W:0] w_b9;
  logic [DATA_W:0] w_cin9;
  logic [DATA_W:0] w_ext;

  assign w_a9   = {1'b0, i_a};
  assign w_b9   = {1'b0, i_b};
  assign w_cin9 = {{DATA_W{1'b0}}, i_cin};

  // Operation decode. Result and carry default to zero so the reserved code
  // (and anything unexpected) yields 0x00 with no carry.
  always_comb begin
    w_ext    = '0;
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_ext    = w_a9 + w_b9;
        o_result = w_ext[DATA_W-1:0];
        o_carry  = w_ext[DATA_W];
      end
      ALU_ADDC: begin
        w_ext    = w_a9 + w_b9 + w_cin9;
        o_result = w_ext[DATA_W-1:0];
        o_carry  = w_ext[DATA_W];
      end
      // CMP produces the same difference as SUB; the control unit simply
      // never writes it back, only the flags matter.
      ALU_SUB, ALU_CMP: begin
        w_ext    = w_a9 - w_b9;
        o_result = w_ext[DATA_W-1:0];
        o_carry  = w_ext[DATA_W];
      end
      ALU_SUBC: begin
        w_ext    = w_a9 - w_b9 - w_cin9;
        o_result = w_ext[DATA_W-1:0];
        o_carry  = w_ext[DATA_W];
      end
      ALU_AND, ALU_TEST: begin
        o_result = i_a & i_b;
      end
      ALU_OR: begin
        o_result = i_a | i_b;
      end
      ALU_EXOR: begin
        o_result = i_a ^ i_b;
      end
      ALU_LSL: begin
        o_result = {i_a[DATA_W-2:0], i_cin};
        o_carry  = i_a[DATA_W-1];
      end
      ALU_LSR: begin
        o_result = {i_cin, i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      ALU_ROL: begin
        o_result = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
        o_carry  = i_a[DATA_W-1];
      end
      ALU_ROR: begin
        o_result = {i_a[0], i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      ALU_ASR: begin
        o_result = {i_a[DATA_W-1], i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      // MOV must leave C untouched if the control unit happens to load it,
      // so the carry output simply reflects the incoming flag.
      ALU_MOV: begin
        o_result = i_b;
        o_carry  = i_cin;
      end
      ALU_RSVD: begin
        o_result = '0;
        o_carry  = 1'b0;
      end
      default: begin
        o_result = '0;
        o_carry  = 1'b0;
      end
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/rat_alu_flags.sv
// ---------------------------------------------------------------------------
// rat_alu_flags
// Execute stage of the RAT CPU: B-operand mux, combinational ALU, and the
// architectural C/Z flags with their interrupt shadow copies.
//   ALU_CLK      : clock, all state updates on the rising edge
//   ALU_RST      : synchronous active-high reset, clears all four flops
//   ALU_A        : X operand from the register file
//   ALU_DY       : Y operand from the register file
//   ALU_IMM      : immediate field from the instruction
//   ALU_B_SEL    : 0 selects ALU_DY, 1 selects ALU_IMM as the B operand
//   ALU_SEL      : operation code
//   FLG_C_LD     : load C from the ALU carry
//   FLG_Z_LD     : load Z from the ALU zero output
//   FLG_C_SET    : force C to 1
//   FLG_C_CLR    : force C to 0 (wins over FLG_C_SET)
//   FLG_SHAD_LD  : copy current C/Z into the shadows (interrupt entry)
//   FLG_LD_SEL   : restore C/Z from the shadows (RETIE), highest priority
//   ALU_RESULT   : combinational result towards the register-file write mux
//   FLG_C        : registered carry flag
//   FLG_Z        : registered zero flag
// ---------------------------------------------------------------------------
module rat_alu_flags
  import rat_alu_pkg::*;
(
  input  logic              ALU_CLK,
  input  logic              ALU_RST,
  input  logic [DATA_W-1:0] ALU_A,
  input  logic [DATA_W-1:0] ALU_DY,
  input  logic [DATA_W-1:0] ALU_IMM,
  input  logic              ALU_B_SEL,
  input  alu_op_t           ALU_SEL,
  input  logic              FLG_C_LD,
  input  logic              FLG_Z_LD,
  input  logic              FLG_C_SET,
  input  logic              FLG_C_CLR,
  input  logic              FLG_SHAD_LD,
  input  logic              FLG_LD_SEL,
  output logic [DATA_W-1:0] ALU_RESULT,
  output logic              FLG_C,
  output logic              FLG_Z
);

  logic              r_c;
  logic              r_z;
  logic              r_shadC;
  logic              r_shadZ;

  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;
  logic              w_carry;
  logic              w_zero;

  assign w_b = ALU_B_SEL ? ALU_IMM : ALU_DY;

  rat_alu_core u_core (
    .i_a      (ALU_A),
    .i_b      (w_b),
    .i_cin    (r_c),
    .i_op     (ALU_SEL),
    .o_result (w_result),
    .o_carry  (w_carry),
    .o_zero   (w_zero)
  );

  // Flag and shadow registers. Every right-hand side below is the pre-edge
  // value, which is what makes SHAD_LD together with LD_SEL a clean swap and
  // lets back-to-back ADDC chains see the carry of the previous instruction.
  always_ff @(posedge ALU_CLK) begin
    if (ALU_RST) begin
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_shadC <= 1'b0;
      r_shadZ <= 1'b0;
    end else begin
      if (FLG_LD_SEL) begin
        r_c <= r_shadC;
      end else if (FLG_C_CLR) begin
        r_c <= 1'b0;
      end else if (FLG_C_SET) begin
        r_c <= 1'b1;
      end else if (FLG_C_LD) begin
        r_c <= w_carry;
      end

      if (FLG_LD_SEL) begin
        r_z <= r_shadZ;
      end else if (FLG_Z_LD) begin
        r_z <= w_zero;
      end

      if (FLG_SHAD_LD) begin
        r_shadC <= r_c;
        r_shadZ <= r_z;
      end
    end
  end

  assign ALU_RESULT = w_result;
  assign FLG_C      = r_c;
  assign FLG_Z      = r_z;

endmodule

// File: tb/tb_rat_alu_flags.sv
// ---------------------------------------------------------------------------
// tb_rat_alu_flags
// Self-checking bench for rat_alu_flags: a table of hand-computed single
// cycle vectors followed by randomized traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_rat_alu_flags;
  import rat_alu_pkg::*;

  // Strobe bundle bit positions: {C_LD, Z_LD, C_SET, C_CLR, SHAD_LD, LD_SEL}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_CLD  = 6'b100000;
  localparam logic [5:0] S_ZLD  = 6'b010000;
  localparam logic [5:0] S_SET  = 6'b001000;
  localparam logic [5:0] S_CLR  = 6'b000100;
  localparam logic [5:0] S_SHD  = 6'b000010;
  localparam logic [5:0] S_LDS  = 6'b000001;

  typedef struct {
    logic       rst;
    alu_op_t    op;
    logic [7:0] a;
    logic [7:0] dy;
    logic [7:0] imm;
    logic       bsel;
    logic [5:0] strb;
    logic       chkRes;
    logic [7:0] expRes;
    logic       expC;
    logic       expZ;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] dy;
  logic [7:0] imm;
  logic       bsel;
  alu_op_t    sel;
  logic       cLd;
  logic       zLd;
  logic       cSet;
  logic       cClr;
  logic       shadLd;
  logic       ldSel;
  logic [7:0] result;
  logic       flgC;
  logic       flgZ;

  int total;
  int bad;

  // Behavioural model state
  bit mC;
  bit mZ;
  bit mSC;
  bit mSZ;

  vec_t tbl[27];

  rat_alu_flags dut (
    .ALU_CLK     (clk),
    .ALU_RST     (rst),
    .ALU_A       (a),
    .ALU_DY      (dy),
    .ALU_IMM     (imm),
    .ALU_B_SEL   (bsel),
    .ALU_SEL     (sel),
    .FLG_C_LD    (cLd),
    .FLG_Z_LD    (zLd),
    .FLG_C_SET   (cSet),
    .FLG_C_CLR   (cClr),
    .FLG_SHAD_LD (shadLd),
    .FLG_LD_SEL  (ldSel),
    .ALU_RESULT  (result),
    .FLG_C       (flgC),
    .FLG_Z       (flgZ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t v(logic r, alu_op_t op, logic [7:0] va, logic [7:0] vdy,
                             logic [7:0] vimm, logic vb, logic [5:0] s, logic chk,
                             logic [7:0] er, logic ec, logic ez);
    vec_t t;
    t.rst = r; t.op = op; t.a = va; t.dy = vdy; t.imm = vimm; t.bsel = vb;
    t.strb = s; t.chkRes = chk; t.expRes = er; t.expC = ec; t.expZ = ez;
    return t;
  endfunction

  // Reference ALU written as plain integer arithmetic on operand values
  function automatic void modelAlu(input int op, input int va, input int vb, input int cin,
                                   output int res, output int cy);
    int s;
    res = 0;
    cy  = 0;
    case (op)
      0:  begin s = va + vb;       res = s % 256; cy = (s > 255) ? 1 : 0; end
      1:  begin s = va + vb + cin; res = s % 256; cy = (s > 255) ? 1 : 0; end
      2, 4: begin s = va - vb;     res = (s + 256) % 256; cy = (s < 0) ? 1 : 0; end
      3:  begin s = va - vb - cin; res = (s + 512) % 256; cy = (s < 0) ? 1 : 0; end
      5, 8: res = va & vb;
      6:  res = va | vb;
      7:  res = va ^ vb;
      9:  begin res = (va * 2 + cin) % 256;      cy = va / 128; end
      10: begin res = va / 2 + cin * 128;        cy = va % 2; end
      11: begin res = (va * 2) % 256 + va / 128; cy = va / 128; end
      12: begin res = va / 2 + (va % 2) * 128;   cy = va % 2; end
      13: begin res = va / 2 + (va / 128) * 128; cy = va % 2; end
      14: begin res = vb; cy = cin; end
      default: begin res = 0; cy = 0; end
    endcase
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst    = t.rst;
    sel    = t.op;
    a      = t.a;
    dy     = t.dy;
    imm    = t.imm;
    bsel   = t.bsel;
    cLd    = t.strb[5];
    zLd    = t.strb[4];
    cSet   = t.strb[3];
    cClr   = t.strb[2];
    shadLd = t.strb[1];
    ldSel  = t.strb[0];
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    int res;
    int cy;
    int bval;
    bit nC;
    bit nZ;
    vec_t r;

    total = 0;
    bad   = 0;

    tbl[0]  = v(1, ALU_ADD,  8'h00, 8'h00, 8'h00, 0, S_SHD|S_LDS|S_SET, 0, 8'h00, 0, 0);
    tbl[1]  = v(0, ALU_ADD,  8'hFF, 8'h01, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h00, 1, 1);
    tbl[2]  = v(0, ALU_ADDC, 8'h10, 8'h77, 8'h0F, 1, S_CLD|S_ZLD,       1, 8'h20, 0, 0);
    tbl[3]  = v(0, ALU_ADDC, 8'hF0, 8'h10, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h00, 1, 1);
    tbl[4]  = v(0, ALU_LSR,  8'h81, 8'h00, 8'h00, 0, S_CLD|S_ZLD,       1, 8'hC0, 1, 0);
    tbl[5]  = v(0, ALU_ROL,  8'h81, 8'h00, 8'h00, 0, S_CLD,             1, 8'h03, 1, 0);
    tbl[6]  = v(0, ALU_ASR,  8'h81, 8'h00, 8'h00, 0, S_CLD,             1, 8'hC0, 1, 0);
    tbl[7]  = v(0, ALU_CMP,  8'h05, 8'h07, 8'h00, 0, S_CLD|S_ZLD,       1, 8'hFE, 1, 0);
    tbl[8]  = v(0, ALU_CMP,  8'h07, 8'h07, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h00, 0, 1);
    tbl[9]  = v(0, ALU_ADD,  8'h01, 8'h00, 8'h00, 0, S_SET|S_ZLD,       1, 8'h01, 1, 0);
    tbl[10] = v(0, ALU_MOV,  8'h00, 8'h55, 8'h00, 0, S_SHD,             1, 8'h55, 1, 0);
    tbl[11] = v(0, ALU_AND,  8'hF0, 8'h0F, 8'h00, 0, S_CLR|S_ZLD,       1, 8'h00, 0, 1);
    tbl[12] = v(0, ALU_OR,   8'h12, 8'h21, 8'h00, 0, S_LDS,             1, 8'h33, 1, 0);
    tbl[13] = v(0, ALU_SUB,  8'h03, 8'h03, 8'h00, 0, S_CLR|S_ZLD,       1, 8'h00, 0, 1);
    tbl[14] = v(0, ALU_EXOR, 8'hAA, 8'hAA, 8'h00, 0, S_SHD|S_LDS|S_CLD|S_ZLD, 1, 8'h00, 1, 0);
    tbl[15] = v(0, ALU_EXOR, 8'hAA, 8'h55, 8'h00, 0, S_LDS,             1, 8'hFF, 0, 1);
    tbl[16] = v(0, ALU_ADD,  8'hFF, 8'hFF, 8'h00, 0, S_SET|S_CLR|S_CLD, 1, 8'hFE, 0, 1);
    tbl[17] = v(0, ALU_ADD,  8'h01, 8'h01, 8'h00, 0, S_SET|S_CLD,       1, 8'h02, 1, 1);
    tbl[18] = v(0, ALU_MOV,  8'h00, 8'h11, 8'h9C, 1, S_SHD,             1, 8'h9C, 1, 1);
    tbl[19] = v(1, ALU_ADD,  8'h00, 8'h00, 8'h00, 0, S_LDS|S_SHD|S_SET|S_ZLD, 0, 8'h00, 0, 0);
    tbl[20] = v(0, ALU_RSVD, 8'hFF, 8'hFF, 8'h00, 0, S_LDS|S_ZLD,       1, 8'h00, 0, 0);
    tbl[21] = v(0, ALU_SUBC, 8'h10, 8'h05, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h0B, 0, 0);
    tbl[22] = v(0, ALU_MOV,  8'h00, 8'h00, 8'h00, 0, S_SET,             1, 8'h00, 1, 0);
    tbl[23] = v(0, ALU_SUBC, 8'h05, 8'h05, 8'h00, 0, S_CLD|S_ZLD,       1, 8'hFF, 1, 0);
    tbl[24] = v(0, ALU_LSL,  8'h40, 8'h00, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h81, 0, 0);
    tbl[25] = v(0, ALU_ROR,  8'h01, 8'h00, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h80, 1, 0);
    tbl[26] = v(0, ALU_TEST, 8'h0F, 8'hF0, 8'h00, 0, S_CLD|S_ZLD,       1, 8'h00, 0, 1);

    applyStimulus(v(1, ALU_ADD, 8'h00, 8'h00, 8'h00, 0, S_NONE, 0, 8'h00, 0, 0));
    @(posedge clk);
    #1;

    // Directed table: result checked mid-cycle, flags checked after the edge
    for (int i = 0; i < 27; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      if (tbl[i].chkRes) checkOutput("tblResult", i, result, tbl[i].expRes);
      @(posedge clk);
      #1;
      checkOutput("tblC", i, {7'd0, flgC}, {7'd0, tbl[i].expC});
      checkOutput("tblZ", i, {7'd0, flgZ}, {7'd0, tbl[i].expZ});
    end

    // Randomized traffic checked against the behavioural model
    applyStimulus(v(1, ALU_ADD, 8'h00, 8'h00, 8'h00, 0, S_NONE, 0, 8'h00, 0, 0));
    @(posedge clk);
    #1;
    mC = 0; mZ = 0; mSC = 0; mSZ = 0;

    for (int n = 0; n < 600; n++) begin
      r.rst    = ($urandom_range(0, 40) == 0);
      r.op     = alu_op_t'($urandom_range(0, 15));
      r.a      = 8'($urandom_range(0, 255));
      r.dy     = 8'($urandom_range(0, 255));
      r.imm    = 8'($urandom_range(0, 255));
      r.bsel   = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k++) r.strb[k] = ($urandom_range(0, 3) == 0);
      r.chkRes = 1;
      r.expRes = 0; r.expC = 0; r.expZ = 0;
      applyStimulus(r);

      bval = r.bsel ? int'(r.imm) : int'(r.dy);
      modelAlu(int'(r.op), int'(r.a), bval, int'(mC), res, cy);

      @(negedge clk);
      checkOutput("rndResult", n, result, 8'(res));

      if (r.rst) begin
        nC = 0; nZ = 0; mSC = 0; mSZ = 0;
      end else begin
        nC = mC;
        nZ = mZ;
        if (r.strb[0])      nC = mSC;
        else if (r.strb[2]) nC = 0;
        else if (r.strb[3]) nC = 1;
        else if (r.strb[5]) nC = (cy != 0);
        if (r.strb[0])      nZ = mSZ;
        else if (r.strb[4]) nZ = (res == 0);
        if (r.strb[1]) begin
          mSC = mC;
          mSZ = mZ;
        end
      end
      mC = nC;
      mZ = nZ;

      @(posedge clk);
      #1;
      checkOutput("rndC", n, {7'd0, flgC}, {7'd0, mC});
      checkOutput("rndZ", n, {7'd0, flgZ}, {7'd0, mZ});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
